// File: rtl/amp_i2c_slave.sv
// amp_i2c_slave: I2C target for the amp register bus.
// Oversamples SCL/SDA on clk_in, decodes START/STOP, accepts register
// pointer + block writes, serves sequential reads, and drives SDA as
// open-drain (sdao = 0 pulls low, 1 releases). The register file sits
// outside this block behind reg_addr / reg_wdata / reg_wr / reg_rdata.

module amp_i2c_slave #(
    parameter logic [6:0] I2C_ADDR    = 7'b0100000,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_in,
    input  logic       resetb,
    input  logic       scl,
    input  logic       sdai,
    output logic       sdao,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_hist;
    logic                   sda_hist;

    logic [3:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       rw;
    logic       ack_seen;

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_cond;
    logic stop_cond;

    // Synchronise the raw pins and keep one history sample for edge detection.
    // Flops reset to the idle-bus level (high) so reset never fakes a START.
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sdai};
            scl_hist <= scl_sync[SYNC_STAGES-1];
            sda_hist <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // Bus events, all derived from the synchronised signals.
    always_comb begin
        scl_rise   = scl_s & ~scl_hist;
        scl_fall   = ~scl_s & scl_hist;
        start_cond = scl_s & scl_hist & sda_hist & ~sda_s;
        stop_cond  = scl_s & scl_hist & ~sda_hist & sda_s;
    end

    // Protocol FSM: bus conditions first, then per-state bit handling.
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            state     <= IDLE;
            sdao      <= 1'b1;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            reg_wr    <= 1'b0;
            busy      <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            bit_cnt   <= 4'd0;
            shift_reg <= 8'h00;
            rw        <= 1'b0;
            ack_seen  <= 1'b0;
        end else begin
            start_det <= start_cond;
            stop_det  <= stop_cond;
            reg_wr    <= 1'b0;

            // The pointer advances the cycle after a completed write strobe.
            if (reg_wr) begin
                reg_addr <= reg_addr + 8'd1;
            end

            if (stop_cond) begin
                state    <= IDLE;
                sdao     <= 1'b1;
                bit_cnt  <= 4'd0;
                busy     <= 1'b0;
                ack_seen <= 1'b0;
            end else if (start_cond) begin
                state    <= ADDR;
                sdao     <= 1'b1;
                bit_cnt  <= 4'd0;
                ack_seen <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        sdao <= 1'b1;
                    end

                    ADDR: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shift_reg <= {shift_reg[6:0], sda_s};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (shift_reg[7:1] == I2C_ADDR) begin
                                sdao  <= 1'b0;
                                busy  <= 1'b1;
                                rw    <= shift_reg[0];
                                state <= ADDR_ACK;
                            end else begin
                                sdao  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IGNORE;
                            end
                        end
                    end

                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            if (rw) begin
                                shift_reg <= reg_rdata;
                                sdao      <= reg_rdata[7];
                                state     <= RDATA;
                            end else begin
                                sdao  <= 1'b1;
                                state <= PTR;
                            end
                        end
                    end

                    PTR: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shift_reg <= {shift_reg[6:0], sda_s};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            reg_addr <= shift_reg;
                            sdao     <= 1'b0;
                            state    <= PTR_ACK;
                        end
                    end

                    PTR_ACK: begin
                        if (scl_fall) begin
                            sdao    <= 1'b1;
                            bit_cnt <= 4'd0;
                            state   <= WDATA;
                        end
                    end

                    WDATA: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shift_reg <= {shift_reg[6:0], sda_s};
                            bit_cnt   <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                reg_wdata <= {shift_reg[6:0], sda_s};
                                reg_wr    <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sdao  <= 1'b0;
                            state <= WDATA_ACK;
                        end
                    end

                    WDATA_ACK: begin
                        if (scl_fall) begin
                            sdao    <= 1'b1;
                            bit_cnt <= 4'd0;
                            state   <= WDATA;
                        end
                    end

                    RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd7) begin
                                sdao    <= 1'b1;
                                bit_cnt <= 4'd0;
                                state   <= RDATA_ACK;
                            end else begin
                                shift_reg <= {shift_reg[6:0], 1'b0};
                                sdao      <= shift_reg[6];
                                bit_cnt   <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    RDATA_ACK: begin
                        if (scl_rise && !ack_seen) begin
                            reg_addr <= reg_addr + 8'd1;
                            if (sda_s) begin
                                state <= IGNORE;
                            end else begin
                                ack_seen <= 1'b1;
                            end
                        end else if (scl_fall && ack_seen) begin
                            ack_seen  <= 1'b0;
                            shift_reg <= reg_rdata;
                            sdao      <= reg_rdata[7];
                            bit_cnt   <= 4'd0;
                            state     <= RDATA;
                        end
                    end

                    IGNORE: begin
                        sdao <= 1'b1;
                    end

                    default: begin
                        sdao  <= 1'b1;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_amp_i2c_slave.sv
// tb_amp_i2c_slave: bit-banged I2C master driving amp_i2c_slave over a
// wired-AND SDA, with a register-file model (rdata = addr ^ 0xA5) and a
// scoreboard monitor that owns all comparisons.

module tb_amp_i2c_slave;

    localparam int Q = 4;
    localparam int H = 8;

    logic       clk_in = 1'b0;
    logic       resetb;
    logic       scl;
    logic       master_sda;
    logic       sdai;
    logic       sdao;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       start_det;
    logic       stop_det;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    wr_t        exp_wr_q[$];
    chk_t       chk_q[$];
    logic [7:0] rd_exp_q[$];
    logic [7:0] rd_obs_q[$];

    int checks       = 0;
    int errors       = 0;
    int start_cnt    = 0;
    int stop_cnt     = 0;
    int sdao_low_cnt = 0;

    amp_i2c_slave #(
        .I2C_ADDR   (7'b0100000),
        .SYNC_STAGES(2)
    ) dut (
        .clk_in   (clk_in),
        .resetb   (resetb),
        .scl      (scl),
        .sdai     (sdai),
        .sdao     (sdao),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_wr   (reg_wr),
        .reg_rdata(reg_rdata),
        .busy     (busy),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    always #5 clk_in = ~clk_in;

    assign sdai      = master_sda & sdao;
    assign reg_rdata = reg_addr ^ 8'hA5;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: drains queued checks, matches write strobes and read bytes.
    always @(negedge clk_in) begin
        chk_t       c;
        wr_t        w;
        logic [7:0] re;
        logic [7:0] ro;
        if (start_det) start_cnt++;
        if (stop_det) stop_cnt++;
        if (!sdao) sdao_low_cnt++;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            compare(c.name, c.act, c.exp);
        end
        if (reg_wr) begin
            if (exp_wr_q.size() == 0) begin
                compare("unexpected_reg_wr", {16'h0, reg_addr, reg_wdata}, 32'hFFFF_FFFF);
            end else begin
                w = exp_wr_q.pop_front();
                compare("wr_addr", 32'(reg_addr), 32'(w.addr));
                compare("wr_data", 32'(reg_wdata), 32'(w.data));
            end
        end
        while (rd_obs_q.size() > 0) begin
            ro = rd_obs_q.pop_front();
            if (rd_exp_q.size() == 0) begin
                compare("unexpected_rd_byte", 32'(ro), 32'hFFFF_FFFF);
            end else begin
                re = rd_exp_q.pop_front();
                compare("rd_byte", 32'(ro), 32'(re));
            end
        end
    end

    task automatic expect_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk_in);
    endtask

    task automatic i2c_start();
        master_sda = 1'b1;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(Q);
        master_sda = 1'b0;
        wait_clks(Q);
        scl = 1'b0;
        wait_clks(Q);
    endtask

    task automatic i2c_stop();
        master_sda = 1'b0;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(Q);
        master_sda = 1'b1;
        wait_clks(H);
    endtask

    task automatic write_bit(input logic b);
        master_sda = b;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(H);
        scl = 1'b0;
        wait_clks(Q);
    endtask

    task automatic read_bit(output logic v);
        master_sda = 1'b1;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(H / 2);
        v = sdai;
        wait_clks(H / 2);
        scl = 1'b0;
        wait_clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string name);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(a);
        expect_val(name, 32'(a), 32'(exp_ack));
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic ack_bit);
        logic [7:0] r;
        logic       v;
        rd_exp_q.push_back(exp);
        for (int i = 7; i >= 0; i--) begin
            read_bit(v);
            r[i] = v;
        end
        rd_obs_q.push_back(r);
        write_bit(ack_bit);
    endtask

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #500us;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        int s0;
        int p0;
        int lo0;

        resetb     = 1'b0;
        scl        = 1'b1;
        master_sda = 1'b1;
        wait_clks(4);
        expect_val("rst_sdao", 32'(sdao), 32'd1);
        expect_val("rst_reg_addr", 32'(reg_addr), 32'h00);
        expect_val("rst_reg_wdata", 32'(reg_wdata), 32'h00);
        expect_val("rst_reg_wr", 32'(reg_wr), 32'd0);
        expect_val("rst_busy", 32'(busy), 32'd0);
        expect_val("rst_start_det", 32'(start_det), 32'd0);
        expect_val("rst_stop_det", 32'(stop_det), 32'd0);
        @(negedge clk_in);
        resetb = 1'b1;
        wait_clks(4);

        // Single write 0x40 <- 0x18
        s0 = start_cnt;
        p0 = stop_cnt;
        i2c_start();
        write_byte(8'h40, 1'b0, "t1_addr_ack");
        expect_val("t1_busy_after_match", 32'(busy), 32'd1);
        write_byte(8'h40, 1'b0, "t1_ptr_ack");
        exp_wr_q.push_back('{addr: 8'h40, data: 8'h18});
        write_byte(8'h18, 1'b0, "t1_data_ack");
        i2c_stop();
        wait_clks(4);
        expect_val("t1_reg_addr_after", 32'(reg_addr), 32'h41);
        expect_val("t1_busy_after_stop", 32'(busy), 32'd0);
        expect_val("t1_start_pulses", 32'(start_cnt - s0), 32'd1);
        expect_val("t1_stop_pulses", 32'(stop_cnt - p0), 32'd1);

        // Wrong address is ignored entirely
        s0  = start_cnt;
        p0  = stop_cnt;
        lo0 = sdao_low_cnt;
        i2c_start();
        write_byte(8'h42, 1'b1, "t2_addr_nack");
        expect_val("t2_busy_after_addr", 32'(busy), 32'd0);
        write_byte(8'h35, 1'b1, "t2_data_nack");
        i2c_stop();
        wait_clks(4);
        expect_val("t2_sdao_never_low", 32'(sdao_low_cnt - lo0), 32'd0);
        expect_val("t2_busy", 32'(busy), 32'd0);
        expect_val("t2_start_pulses", 32'(start_cnt - s0), 32'd1);
        expect_val("t2_stop_pulses", 32'(stop_cnt - p0), 32'd1);

        // Block write wrapping through 0xFF
        i2c_start();
        write_byte(8'h40, 1'b0, "t3_addr_ack");
        write_byte(8'hFE, 1'b0, "t3_ptr_ack");
        exp_wr_q.push_back('{addr: 8'hFE, data: 8'h11});
        write_byte(8'h11, 1'b0, "t3_d0_ack");
        exp_wr_q.push_back('{addr: 8'hFF, data: 8'h22});
        write_byte(8'h22, 1'b0, "t3_d1_ack");
        exp_wr_q.push_back('{addr: 8'h00, data: 8'h33});
        write_byte(8'h33, 1'b0, "t3_d2_ack");
        i2c_stop();
        wait_clks(4);
        expect_val("t3_reg_addr_after", 32'(reg_addr), 32'h01);

        // Read via repeated START: 0x35^0xA5=0x90, 0x36^0xA5=0x93
        s0 = start_cnt;
        i2c_start();
        write_byte(8'h40, 1'b0, "t4_waddr_ack");
        write_byte(8'h35, 1'b0, "t4_ptr_ack");
        i2c_start();
        write_byte(8'h41, 1'b0, "t4_raddr_ack");
        read_byte(8'h90, 1'b0);
        read_byte(8'h93, 1'b1);
        wait_clks(2);
        expect_val("t4_reg_addr_after", 32'(reg_addr), 32'h37);
        expect_val("t4_busy_before_stop", 32'(busy), 32'd1);
        lo0 = sdao_low_cnt;
        write_bit(1'b0);
        write_bit(1'b0);
        expect_val("t4_ignore_no_drive", 32'(sdao_low_cnt - lo0), 32'd0);
        i2c_stop();
        wait_clks(4);
        expect_val("t4_busy_after_stop", 32'(busy), 32'd0);
        expect_val("t4_start_pulses", 32'(start_cnt - s0), 32'd2);

        // Abort a write byte after 5 bits with STOP
        i2c_start();
        write_byte(8'h40, 1'b0, "t5_addr_ack");
        write_byte(8'h50, 1'b0, "t5_ptr_ack");
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        i2c_stop();
        wait_clks(4);
        expect_val("t5_reg_addr_kept", 32'(reg_addr), 32'h50);
        expect_val("t5_sdao_released", 32'(sdao), 32'd1);
        expect_val("t5_busy_idle", 32'(busy), 32'd0);
        i2c_start();
        write_byte(8'h40, 1'b0, "t5b_addr_ack");
        write_byte(8'h60, 1'b0, "t5b_ptr_ack");
        exp_wr_q.push_back('{addr: 8'h60, data: 8'h7E});
        write_byte(8'h7E, 1'b0, "t5b_data_ack");
        i2c_stop();
        wait_clks(4);
        expect_val("t5b_reg_addr_after", 32'(reg_addr), 32'h61);

        // Async reset while the address ACK is being driven
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(1'(8'h40 >> i));
        master_sda = 1'b1;
        wait_clks(Q);
        expect_val("t6_ack_driven", 32'(sdao), 32'd0);
        resetb = 1'b0;
        #1;
        expect_val("t6_sdao_async", 32'(sdao), 32'd1);
        expect_val("t6_reg_addr", 32'(reg_addr), 32'h00);
        expect_val("t6_reg_wdata", 32'(reg_wdata), 32'h00);
        expect_val("t6_busy", 32'(busy), 32'd0);
        expect_val("t6_reg_wr", 32'(reg_wr), 32'd0);
        wait_clks(3);
        @(negedge clk_in);
        resetb = 1'b1;
        lo0 = sdao_low_cnt;
        s0  = start_cnt;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(H);
        scl = 1'b0;
        wait_clks(Q);
        for (int i = 7; i >= 0; i--) write_bit(1'(8'h40 >> i));
        write_bit(1'b1);
        expect_val("t6_no_ack_after_reset", 32'(sdao_low_cnt - lo0), 32'd0);
        expect_val("t6_no_start_after_reset", 32'(start_cnt - s0), 32'd0);
        i2c_stop();
        i2c_start();
        write_byte(8'h40, 1'b0, "t6b_addr_ack");
        write_byte(8'h10, 1'b0, "t6b_ptr_ack");
        exp_wr_q.push_back('{addr: 8'h10, data: 8'h5A});
        write_byte(8'h5A, 1'b0, "t6b_data_ack");
        i2c_stop();
        wait_clks(4);
        expect_val("t6b_reg_addr_after", 32'(reg_addr), 32'h11);

        expect_val("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
        expect_val("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
        wait_clks(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
